// File: rtl/mult16_seq_pkg.sv
// Shared definitions for the sequential 16x16 shift-add multiplier.
package mult16_seq_pkg;

  localparam int WIDTH = 16;
  localparam int ITERS = 16;
  localparam int CNT_W = $clog2(ITERS);

  // Counter value on the final iteration of a multiply.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult16_seq_cla.sv
// 16-bit two-level carry-lookahead adder built from four 4-bit lookahead groups.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [3:0] grp_g;
  logic [3:0] grp_p;
  logic [4:0] grp_c;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      logic [3:0] p;
      logic [3:0] g;
      logic [3:0] c;

      assign p = a[4*gi +: 4] ^ b[4*gi +: 4];
      assign g = a[4*gi +: 4] & b[4*gi +: 4];

      // In-group carries, fully expanded from the group carry-in.
      assign c[0] = grp_c[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c[0]);

      // Group generate / propagate feed the second lookahead level.
      assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]);
      assign grp_p[gi] = &p;

      assign sum[4*gi +: 4] = p ^ c;
    end
  endgenerate

  // Second-level lookahead across the four groups.
  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

  assign cout = grp_c[4];

endmodule

// File: rtl/mult16_seq.sv
// Sequential unsigned 16x16 multiplier: one shift-add iteration per cycle,
// 16 iterations per product, result held in a registered output.
module mult16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod
);

  import mult16_seq_pkg::*;

  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   add_s;
  logic               add_c;
  logic [2*WIDTH-1:0] shifted;

  // Add the multiplicand only when the current multiplier bit is set.
  assign addend = acc_lo_q[0] ? mcand_q : '0;

  cla16 u_cla (
    .a    (acc_hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_c)
  );

  // 33-bit {carry, sum, acc_lo} shifted right by one; the carry lands in bit 31.
  assign shifted = {add_c, add_s, acc_lo_q[WIDTH-1:1]};

  // Next-state and datapath control; accepts start only outside RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    prod_d   = prod_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = a;
          acc_hi_d = '0;
          acc_lo_d = b;
          cnt_d    = '0;
          state_d  = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        {acc_hi_d, acc_lo_d} = shifted;
        cnt_d                = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          prod_d  = shifted;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      prod_q   <= prod_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign prod = prod_q;

endmodule

// File: doc/mult16_seq.md
MULT16_SEQ -- requirements
Module: mult16_seq

Interface
REQ-001 Parameters: none; operand width is fixed at 16 bits and iteration count at 16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled only when busy=0.
REQ-005 a  input  16  multiplicand, unsigned; captured on an accepted start.
REQ-006 b  input  16  multiplier, unsigned; captured on an accepted start.
REQ-007 busy  output  1  high while an iteration sequence is in progress.
REQ-008 done  output  1  one-cycle pulse: prod holds a new result.
REQ-009 prod  output  32  registered product a*b; held until the next completion.

Function
REQ-010 The block SHALL use three states: IDLE, RUN and DONE.
REQ-011 A start SHALL be accepted in IDLE or DONE; an accepted start captures a and b, clears the 4-bit iteration counter, loads acc_hi=0 and acc_lo=b, and enters RUN.
REQ-012 In RUN, one iteration SHALL complete per cycle.
REQ-013 Each iteration: if acc_lo[0]=1, {c,s} = acc_hi + mcand (16-bit carry-lookahead add, Cin=0); otherwise {c,s} = {0,acc_hi}.
REQ-014 Each iteration then updates {acc_hi,acc_lo} <= {c,s,acc_lo[15:1]} (33-bit right shift) and increments the counter.
REQ-015 On the RUN edge where counter=15, the block SHALL write the shifted 32-bit result to prod and enter DONE.
REQ-016 Latency: a start accepted at edge k SHALL give busy=1 for edges k+1..k+16, prod valid and done=1 in the cycle after edge k+16.
REQ-017 busy = (state==RUN); done = (state==DONE); both SHALL be driven from registered state only, with no combinational path from start.
REQ-018 DONE SHALL last exactly one cycle and then go to IDLE, or to RUN if start=1 in DONE (back-to-back; done still pulses for the finished op).
REQ-019 start asserted while busy=1 SHALL be ignored, with no effect on operands, counter or prod.
REQ-020 Changes on a or b after acceptance SHALL NOT affect the result in progress.
REQ-021 prod SHALL change only on the completion edge or on reset.
REQ-022 Zero operands SHALL NOT terminate early; the latency is always 16 iterations.
REQ-023 Width rule: the adder carry out SHALL be kept as bit 32 of the shift; no overflow is possible (max 0xFFFF*0xFFFF = 0xFFFE0001).

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE, counter=0, accumulator=0, prod=0x00000000, busy=0, done=0.
REQ-025 Reset SHALL take priority over start and over any in-progress RUN; an aborted operation produces no done and leaves prod=0.
REQ-026 start sampled in the same cycle as rst=1 SHALL be discarded.

Structure
REQ-027 A shared package/include SHALL hold the state encodings (IDLE, RUN, DONE), WIDTH=16 and ITERS=16.
REQ-028 The add SHALL be one instance of the team's existing 16-bit carry-lookahead adder (cla16), Cin tied to 0 and Cout used as c.
REQ-029 The only other datapath logic SHALL be the operand mux (mcand or 0), the shift register, the counter and the FSM, all in this module.

Verification
REQ-030 a=3, b=5, start one cycle -> busy 16 cycles, done single pulse 16 edges after start, prod=0x0000000F.
REQ-031 a=0xFFFF, b=0xFFFF -> prod=0xFFFE0001; a=0x8000, b=0x0002 -> prod=0x00010000; a=0, b=0x1234 -> prod=0 after full latency.
REQ-032 Start a=7, b=9; at iteration 5 pulse start with a=2, b=2 -> ignored, prod=0x0000003F.
REQ-033 Start a=0x00FF, b=0x0101, then rst at iteration 8 -> next cycle busy=0, done=0, prod=0, and no done pulse follows.
REQ-034 Hold start=1 in the DONE cycle with a=0x0010, b=0x0010 -> done pulses, busy rises next cycle, second prod=0x00000100 16 edges later.
REQ-035 Random unsigned pairs (>=1000) with a reference model -> prod==a*b and the exact latency for every op.
